// File: rtl/signed_seq_divider_if.sv
// Operand/result bundle for the signed sequential divider.
// The master side drives start and operands; the slave returns results and status.
interface signed_seq_divider_if #(
    parameter int N = 6,
    parameter int W = 2 * N
);
    logic         start;
    logic [W-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, overflow, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, overflow, busy, done
    );
endinterface

// File: rtl/signed_seq_divider.sv
// Signed 2N-by-N radix-2 restoring divider, one quotient bit per clock.
// Fixed latency regardless of operands; overflow and divide-by-zero zero the results.
module signed_seq_divider #(
    parameter int INPUT_WIDTH    = 6,
    parameter int DIVIDEND_WIDTH = 12
) (
    input logic                 clk,
    input logic                 rst,
    signed_seq_divider_if.slave bus
);
    localparam int N  = INPUT_WIDTH;
    localparam int W  = DIVIDEND_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [CW-1:0] LAST     = CW'(W - 1);
    localparam logic [W-1:0]  QMAX_POS = W'((1 << (N - 1)) - 1);
    localparam logic [W-1:0]  QMAX_NEG = W'(1 << (N - 1));

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic [N-1:0]  qout_q, qout_d;
    logic [N-1:0]  rout_q, rout_d;
    logic          ovf_q, ovf_d;

    logic [N:0]    part;
    logic          fits;
    logic [N-1:0]  sub;
    logic [W-1:0]  qlim;
    logic          ovf_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        ovf_d   = ovf_q;

        // quo_q starts as the dividend magnitude and fills with quotient bits
        part  = {rem_q, quo_q[W-1]};
        fits  = part >= {1'b0, dvs_q};
        sub   = part[N-1:0] - dvs_q;
        qlim  = qneg_q ? QMAX_NEG : QMAX_POS;
        ovf_c = (dvs_q == '0) || (quo_q > qlim);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = bus.dividend[W-1] ? -bus.dividend
                                                : bus.dividend;
                    dvs_d   = bus.divisor[N-1] ? -bus.divisor
                                               : bus.divisor;
                    qneg_d  = bus.dividend[W-1] ^ bus.divisor[N-1];
                    rneg_d  = bus.dividend[W-1];
                end
            end
            CALC: begin
                if (fits) begin
                    rem_d = sub;
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = part[N-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (ovf_c) begin
                    ovf_d  = 1'b1;
                    qout_d = '0;
                    rout_d = '0;
                end else begin
                    ovf_d  = 1'b0;
                    qout_d = qneg_q ? -quo_q[N-1:0] : quo_q[N-1:0];
                    rout_d = rneg_q ? -rem_q : rem_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            qout_q  <= '0;
            rout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.quotient  = qout_q;
    assign bus.remainder = rout_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench for signed_seq_divider: directed corner cases plus
// randomized operands against an integer-arithmetic reference.
module tb_signed_seq_divider;
    localparam int N   = 6;
    localparam int W   = 2 * N;
    localparam int LAT = 2 * N + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    signed_seq_divider_if #(.N(N), .W(W)) bus ();

    signed_seq_divider #(
        .INPUT_WIDTH   (N),
        .DIVIDEND_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         ovf;
        int           sedge;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int a, int b, int se);
        exp_t e;
        int   q;
        int   r;
        e.sedge = se;
        e.q     = '0;
        e.r     = '0;
        e.ovf   = 1'b1;
        if (b != 0) begin
            q = a / b;
            r = a % b;
            if (q >= -(1 << (N - 1)) && q <= (1 << (N - 1)) - 1) begin
                e.ovf = 1'b0;
                e.q   = N'(q);
                e.r   = N'(r);
            end
        end
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: pops one expectation per done pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("quotient", 32'(bus.quotient), 32'(e.q));
                check("remainder", 32'(bus.remainder), 32'(e.r));
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
                check("latency", 32'(cyc - e.sedge + 1), 32'(LAT));
            end
        end
    end

    task automatic issue(int a, int b, output int se);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = N'(b);
        se           = cyc + 1;
        exp_q.push_back(model(a, b, se));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = N'($urandom);
    endtask

    task automatic wait_idle(int se, bit trace);
        int bad;
        bad = 0;
        while (bus.busy === 1'b1 && cyc - se < 4 * LAT) begin
            if (trace && bus.done !== (cyc - se + 1 == LAT)) bad++;
            @(negedge clk);
        end
        check("busy_span", 32'(cyc - se), 32'(LAT));
        if (trace) check("done_shape", 32'(bad), 32'd0);
    endtask

    task automatic run(int a, int b, bit trace);
        int se;
        issue(a, b, se);
        wait_idle(se, trace);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        int se;
        int se2;
        int a;
        int b;
        int q;
        int bm;
        int rr;
        logic signed [W-1:0] ra;
        logic signed [N-1:0] rb;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run(100, 7, 1'b1);
        run(-100, 7, 1'b0);
        run(-192, 6, 1'b0);
        run(192, 6, 1'b0);
        run(100, 0, 1'b1);
        run(-32, -1, 1'b0);
        run(-2048, 31, 1'b0);
        run(-33, 1, 1'b0);

        // a second start mid-division must not disturb the first
        issue(100, 7, se);
        while (cyc < se + 4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(50);
        bus.divisor  = N'(5);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(se, 1'b1);

        // start held through done: next capture waits for IDLE
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(-100);
        bus.divisor  = N'(-7);
        se           = cyc + 1;
        exp_q.push_back(model(-100, -7, se));
        @(negedge clk);
        bus.dividend = W'(77);
        bus.divisor  = N'(-5);
        se2          = se + LAT + 1;
        exp_q.push_back(model(77, -5, se2));
        while (cyc < se2) @(negedge clk);
        bus.start = 1'b0;
        wait_idle(se2, 1'b0);

        // asynchronous abort in the middle of a division
        issue(100, 7, se);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_q", 32'(bus.quotient), 32'd0);
        check("abort_r", 32'(bus.remainder), 32'd0);
        check("abort_ovf", 32'(bus.overflow), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2 * LAT) @(negedge clk);
        run(-7, 2, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            rb = N'($urandom);
            b  = rb;
            if (i % 4 == 0) begin
                ra = W'($urandom);
                a  = ra;
            end else begin
                q  = int'($urandom_range(0, 63)) - 32;
                bm = (b < 0) ? -b : b;
                rr = (bm == 0) ? 0 : int'($urandom_range(0, bm - 1));
                a  = q * b;
                if (a < 0 || (a == 0 && $urandom_range(0, 1) == 1))
                    a = a - rr;
                else
                    a = a + rr;
            end
            run(a, b, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/signed_seq_divider.md
SIGNED_SEQ_DIVIDER -- requirements
Module: signed_seq_divider

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 6: the divisor, quotient and remainder width (N).
REQ-002 SHALL have parameter DIVIDEND_WIDTH, default 12: the dividend width, fixed at 2*N.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin a division, sampled on the rising edge of clk.
REQ-006 SHALL have port dividend, input, 2N bits: signed two's-complement dividend.
REQ-007 SHALL have port divisor, input, N bits: signed two's-complement divisor.
REQ-008 SHALL have port quotient, output, N bits: signed result, registered.
REQ-009 SHALL have port remainder, output, N bits: signed result, registered.
REQ-010 SHALL have port overflow, output, 1 bit: result not representable, or divide-by-zero; registered.
REQ-011 SHALL have port busy, output, 1 bit: a division is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FIX and DONE; the module leaves reset in IDLE.
REQ-014 SHALL, in IDLE with start=1, capture dividend and divisor into internal registers and enter CALC.
- Input ports are don't-care after the capture.
REQ-015 SHALL take the operand magnitudes on capture and record the quotient sign (XOR of the operand MSBs) and the remainder sign (the dividend MSB).
REQ-016 SHALL, in CALC, perform one radix-2 restoring shift/subtract step per cycle for exactly 2N cycles, using a 2N-bit magnitude quotient and an (N+1)-bit partial remainder, then enter FIX.
REQ-017 SHALL, in FIX (one cycle), apply the signs to the results.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.
- The identity dividend = quotient*divisor + remainder SHALL hold.
REQ-018 SHALL, in FIX, set overflow=1 and force quotient=0 and remainder=0 when the divisor is 0, or when the signed quotient is outside [-2^(N-1), 2^(N-1)-1].
REQ-019 SHALL, in FIX, otherwise set overflow=0 and load quotient and remainder.
REQ-020 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-021 SHALL hold quotient, remainder and overflow stable from DONE until the FIX of the next division.
REQ-022 SHALL assert busy in every cycle the state is CALC, FIX or DONE, and deassert it in IDLE.
REQ-023 SHALL assert done exactly 2N+2 rising edges after the edge that sampled start (14 for N=6), with the same latency for every operand, including zero and overflow cases.
REQ-024 SHALL ignore start while busy=1: no restart, and the captured operands are not disturbed.
REQ-025 SHALL accept a start sampled in the cycle done is high only on the next IDLE cycle.
- Back-to-back throughput is one division per 2N+3 cycles.
REQ-026 SHALL produce the most-negative quotient -2^(N-1) (e.g. 6'h20) without overflow when it is exact or truncates to that value.

Reset
REQ-027 SHALL, with rst=0 asynchronously, force state=IDLE, busy=0, done=0, overflow=0, quotient=0, remainder=0, and clear the internal operand registers.
REQ-028 SHALL, on reset during CALC or FIX, abort the division: no done pulse is produced for it, and the next start after rst=1 runs normally.

Verification
REQ-029 SHALL cover: dividend=100, divisor=7, start -> done at edge 14, quotient=14 (6'h0E), remainder=2, overflow=0, busy high edges 1..14.
REQ-030 SHALL cover: dividend=-100, divisor=7 -> quotient=-14 (6'h32), remainder=-2 (6'h3E), overflow=0; and dividend=-192, divisor=6 -> quotient=-32 (6'h20), remainder=0, overflow=0.
REQ-031 SHALL cover: dividend=192, divisor=6 -> overflow=1, quotient=0, remainder=0; and dividend=100, divisor=0 -> overflow=1, quotient=0, remainder=0, done still at edge 14.
REQ-032 SHALL cover: start for 100/7, then at edge 5 start=1 with operands 50/5 -> ignored, and the result is still 14 rem 2 at edge 14.
REQ-033 SHALL cover: rst=0 asserted between clock edges at cycle 6 of a division -> busy=0 and all outputs 0 immediately, with no done pulse.
- After rst=1, a start for -7/2 -> quotient=-3 (6'h3D), remainder=-1 (6'h3F).
REQ-034 SHALL cover: random signed operands over 1000 runs compared against a reference model, including divisor=-1 with dividend=-32 -> overflow=1.
